ttt_board_ctrl: RTL and testbench

Sequential board-state owner for the TicTacToe game. Holds the nine 2-bit cells, validates and applies player moves, alternates turns, and latches the game result from the downstream detectors (no-space detector and win detector), which combinationally consume its `pos1`..`pos9` outputs. It sits between the move-entry logic (debounced buttons/switches) and the detector and display stages.

---
 rtl/ttt_pkg.sv | 38 +++
 rtl/ttt_board_ctrl.sv | 145 ++++++++++++++
 tb/tb_ttt_board_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ttt_pkg.sv
// ============================================================================
// Module      : ttt_pkg
// Description : Shared types and constants for the TicTacToe datapath.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ttt_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        MARK_X = 2'b01,
        MARK_O = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_X    = 2'b01,
        RES_O    = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        PLAY  = 2'b00,
        CHECK = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [3:0] POS_MIN = 4'd1;
    localparam logic [3:0] POS_MAX = 4'd9;

    function automatic cell_t other_mark(input cell_t c);
        return (c == MARK_X) ? MARK_O : MARK_X;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_board_ctrl.sv
// ============================================================================
// Module      : ttt_board_ctrl
// Description : Board-state owner: validates/applies moves, alternates turns,
//               latches the game result from the external detectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ttt_board_ctrl
    import ttt_pkg::*;
#(
    parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    input  logic       new_game,
    input  logic [1:0] winner,
    input  logic       no_space,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic       move_ack,
    output logic       move_err,
    output logic       game_over,
    output logic [1:0] result
);

    state_t     state_q, state_d;
    cell_t      board_q [9];
    cell_t      board_d [9];
    cell_t      turn_q, turn_d;
    result_t    result_q, result_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;
    logic       game_over_q, game_over_d;
    logic [3:0] idx;
    logic       pos_legal;

    assign idx       = move_pos - POS_MIN;
    assign pos_legal = (move_pos >= POS_MIN) && (move_pos <= POS_MAX);

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        turn_d   = turn_q;
        result_d = result_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;

        if (new_game) begin
            // A move arriving together with new_game is silently dropped.
            for (int i = 0; i < 9; i++) begin
                board_d[i] = EMPTY;
            end
            turn_d   = cell_t'(FIRST_PLAYER);
            result_d = RES_NONE;
            state_d  = PLAY;
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_valid) begin
                        if (pos_legal && (board_q[idx] == EMPTY)) begin
                            board_d[idx] = turn_q;
                            ack_d        = 1'b1;
                            state_d      = CHECK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    err_d = move_valid;
                    // Win is tested before no_space so a winning ninth move is not a draw.
                    if ((winner == 2'b01) || (winner == 2'b10)) begin
                        result_d = result_t'(winner);
                        state_d  = DONE;
                    end else if (no_space) begin
                        result_d = RES_DRAW;
                        state_d  = DONE;
                    end else begin
                        turn_d  = other_mark(turn_q);
                        state_d = PLAY;
                    end
                end
                DONE: begin
                    err_d = move_valid;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end

        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLAY;
            for (int i = 0; i < 9; i++) begin
                board_q[i] <= EMPTY;
            end
            turn_q      <= cell_t'(FIRST_PLAYER);
            result_q    <= RES_NONE;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            turn_q      <= turn_d;
            result_q    <= result_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            game_over_q <= game_over_d;
        end
    end

    assign pos1      = board_q[0];
    assign pos2      = board_q[1];
    assign pos3      = board_q[2];
    assign pos4      = board_q[3];
    assign pos5      = board_q[4];
    assign pos6      = board_q[5];
    assign pos7      = board_q[6];
    assign pos8      = board_q[7];
    assign pos9      = board_q[8];
    assign turn      = turn_q;
    assign move_ack  = ack_q;
    assign move_err  = err_q;
    assign game_over = game_over_q;
    assign result    = result_q;

endmodule

`default_nettype wire

// File: tb/tb_ttt_board_ctrl.sv
// ============================================================================
// Module      : tb_ttt_board_ctrl
// Description : Directed, table-driven self-checking bench for ttt_board_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ttt_board_ctrl;

    typedef struct {
        logic       mv;
        logic [3:0] p;
        logic       ng;
        logic       ack;
        logic       err;
        logic [1:0] turn;
        logic [1:0] res;
        logic       go;
        int         ci;
        logic [1:0] cv;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       move_valid;
    logic [3:0] move_pos;
    logic       new_game;
    logic [1:0] winner;
    logic       no_space;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] turn;
    logic       move_ack;
    logic       move_err;
    logic       game_over;
    logic [1:0] result;

    logic [1:0] cells [1:9];
    vec_t       vq [$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    ttt_board_ctrl #(.FIRST_PLAYER(2'b01)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .move_valid(move_valid),
        .move_pos  (move_pos),
        .new_game  (new_game),
        .winner    (winner),
        .no_space  (no_space),
        .pos1      (pos1),
        .pos2      (pos2),
        .pos3      (pos3),
        .pos4      (pos4),
        .pos5      (pos5),
        .pos6      (pos6),
        .pos7      (pos7),
        .pos8      (pos8),
        .pos9      (pos9),
        .turn      (turn),
        .move_ack  (move_ack),
        .move_err  (move_err),
        .game_over (game_over),
        .result    (result)
    );

    assign cells[1] = pos1;
    assign cells[2] = pos2;
    assign cells[3] = pos3;
    assign cells[4] = pos4;
    assign cells[5] = pos5;
    assign cells[6] = pos6;
    assign cells[7] = pos7;
    assign cells[8] = pos8;
    assign cells[9] = pos9;

    // Stand-in for the downstream win / no-space detectors.
    always_comb begin
        winner   = 2'b00;
        no_space = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (cells[i] == 2'b00) no_space = 1'b0;
        end
        for (int m = 1; m <= 2; m++) begin
            logic [1:0] k;
            k = 2'(m);
            if ((cells[1] == k && cells[2] == k && cells[3] == k) ||
                (cells[4] == k && cells[5] == k && cells[6] == k) ||
                (cells[7] == k && cells[8] == k && cells[9] == k) ||
                (cells[1] == k && cells[4] == k && cells[7] == k) ||
                (cells[2] == k && cells[5] == k && cells[8] == k) ||
                (cells[3] == k && cells[6] == k && cells[9] == k) ||
                (cells[1] == k && cells[5] == k && cells[9] == k) ||
                (cells[3] == k && cells[5] == k && cells[7] == k))
                winner = k;
        end
    end

    task automatic add(input logic mv, input logic [3:0] p, input logic ng,
                       input logic ack, input logic err, input logic [1:0] t,
                       input logic [1:0] res, input logic go,
                       input int ci, input logic [1:0] cv);
        vec_t v;
        v.mv = mv; v.p = p; v.ng = ng; v.ack = ack; v.err = err;
        v.turn = t; v.res = res; v.go = go; v.ci = ci; v.cv = cv;
        vq.push_back(v);
    endtask

    // Alternating moves starting with X, each followed by an idle CHECK cycle.
    task automatic play_seq(input int ps[9], input int n, input logic [1:0] fin);
        logic [1:0] t;
        t = 2'b01;
        for (int i = 0; i < n; i++) begin
            add(1'b1, 4'(ps[i]), 1'b0, 1'b1, 1'b0, t, 2'b00, 1'b0, ps[i], t);
            if (i == n - 1 && fin != 2'b00) begin
                add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, t, fin, 1'b1, ps[i], t);
            end else begin
                t = (t == 2'b01) ? 2'b10 : 2'b01;
                add(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, t, 2'b00, 1'b0, ps[i], 2'(3 - int'(t)));
            end
        end
    endtask

    task automatic check_outs(input string name, input logic ack, input logic err,
                              input logic [1:0] t, input logic [1:0] res,
                              input logic go, input int ci, input logic [1:0] cv);
        checks++;
        if (move_ack !== ack || move_err !== err || turn !== t ||
            result !== res || game_over !== go || cells[ci] !== cv) begin
            errors++;
            $display("FAIL %s: got ack=%b err=%b turn=%b result=%b game_over=%b pos%0d=%b, expected ack=%b err=%b turn=%b result=%b game_over=%b pos%0d=%b",
                     name, move_ack, move_err, turn, result, game_over, ci, cells[ci],
                     ack, err, t, res, go, ci, cv);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        move_valid = 1'b0;
        move_pos   = 4'd0;
        new_game   = 1'b0;

        add(1'b1, 4'd5,  1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 5, 2'b01);
        add(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 5, 2'b01);
        add(1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 5, 2'b01);
        add(1'b1, 4'd0,  1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 5, 2'b01);
        add(1'b1, 4'd12, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 5, 2'b01);
        add(1'b1, 4'd1,  1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1, 2'b10);
        add(1'b1, 4'd2,  1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2, 2'b00);
        add(1'b1, 4'd3,  1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 3, 2'b00);
        add(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 5, 2'b00);
        // Row 1-2-3 win for X.
        play_seq('{1, 4, 2, 5, 3, 0, 0, 0, 0}, 5, 2'b01);
        add(1'b1, 4'd6,  1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 1'b1, 6, 2'b00);
        add(1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b1, 3, 2'b01);
        add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1, 2'b00);
        // Full board, no line: draw.
        play_seq('{1, 2, 3, 5, 4, 6, 8, 7, 9}, 9, 2'b11);
        add(1'b1, 4'd5,  1'b0, 1'b0, 1'b1, 2'b01, 2'b11, 1'b1, 5, 2'b10);
        add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 9, 2'b00);
        // Ninth move fills the board and completes 1-5-9: a win.
        play_seq('{1, 3, 2, 4, 5, 7, 6, 8, 9}, 9, 2'b01);
        add(1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 9, 2'b00);

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset_state", 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 5, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            move_valid = vq[i].mv;
            move_pos   = vq[i].p;
            new_game   = vq[i].ng;
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vq[i].ack, vq[i].err, vq[i].turn,
                       vq[i].res, vq[i].go, vq[i].ci, vq[i].cv);
        end

        // Asynchronous reset asserted while the controller is in CHECK.
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd5;
        new_game   = 1'b0;
        @(posedge clk);
        #1;
        check_outs("pre_reset_move", 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 5, 2'b01);
        move_valid = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check_outs("async_reset_in_check", 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 5, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        move_valid = 1'b1;
        move_pos   = 4'd9;
        @(posedge clk);
        #1;
        check_outs("move_after_reset", 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 9, 2'b01);
        @(negedge clk);
        move_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
